// File: rtl/decode_support_unit.sv
// Instruction-decode support: 32x32 register file, opcode control decoder and
// load-use hazard detector feeding the ID/EX pipeline register.
module decode_support_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opCode,
  input  logic [4:0]  readRegister1,
  input  logic [4:0]  readRegister2,
  input  logic [4:0]  writeRegister,
  input  logic [31:0] writeData,
  input  logic        regWrite,
  input  logic        idExMemRead,
  input  logic [4:0]  idExRt,
  output logic [31:0] readData1,
  output logic [31:0] readData2,
  output logic [1:0]  writeBackControl,
  output logic [2:0]  memAccessControl,
  output logic [3:0]  calculationControl,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        bubbleInstruction
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [31:0] regs_q [32];
  logic [8:0]  ctrl;
  logic        stall;

  // r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (regWrite && (writeRegister != 5'd0)) begin
      regs_q[writeRegister] <= writeData;
    end
  end

  // No bypass: a value written at the rising edge appears here right after it.
  assign readData1 = (readRegister1 == 5'd0) ? 32'd0 : regs_q[readRegister1];
  assign readData2 = (readRegister2 == 5'd0) ? 32'd0 : regs_q[readRegister2];

  // ctrl = {WB[1:0], MEM[2:0], EX[3:0]}; unknown opcodes decode as a NOP.
  always_comb begin
    ctrl = 9'b00_000_0000;
    case (opCode)
      OP_RTYPE: ctrl = 9'b10_000_1100;
      OP_LW:    ctrl = 9'b11_010_0001;
      OP_SW:    ctrl = 9'b00_001_0001;
      OP_BEQ:   ctrl = 9'b00_100_0010;
      OP_ADDI:  ctrl = 9'b10_000_0001;
      default:  ctrl = 9'b00_000_0000;
    endcase
  end

  assign writeBackControl   = ctrl[8:7];
  assign memAccessControl   = ctrl[6:4];
  assign calculationControl = ctrl[3:0];

  // Register 0 is deliberately not excluded from the load-use compare.
  assign stall = idExMemRead && ((idExRt == readRegister1) || (idExRt == readRegister2));

  assign pcWrite           = ~stall;
  assign ifIdWrite         = ~stall;
  assign bubbleInstruction = stall;

endmodule

// File: tb/tb_decode_support_unit.sv
// Bench for decode_support_unit: directed checks from the test plan plus a
// randomized run compared every falling edge against a behavioural model.
module tb_decode_support_unit;

  localparam int W = 76;

  logic        clk;
  logic        reset;
  logic [5:0]  opCode;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        regWrite;
  logic        idExMemRead;
  logic [4:0]  idExRt;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [1:0]  writeBackControl;
  logic [2:0]  memAccessControl;
  logic [3:0]  calculationControl;
  logic        pcWrite;
  logic        ifIdWrite;
  logic        bubbleInstruction;

  int passed = 0;
  int total  = 0;
  logic chk_en = 1'b0;

  logic [31:0] model_regs [32];
  logic [W-1:0] exp_q[$];

  decode_support_unit dut (
    .clk               (clk),
    .reset             (reset),
    .opCode            (opCode),
    .readRegister1     (readRegister1),
    .readRegister2     (readRegister2),
    .writeRegister     (writeRegister),
    .writeData         (writeData),
    .regWrite          (regWrite),
    .idExMemRead       (idExMemRead),
    .idExRt            (idExRt),
    .readData1         (readData1),
    .readData2         (readData2),
    .writeBackControl  (writeBackControl),
    .memAccessControl  (memAccessControl),
    .calculationControl(calculationControl),
    .pcWrite           (pcWrite),
    .ifIdWrite         (ifIdWrite),
    .bubbleInstruction (bubbleInstruction)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the register file state.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (regWrite && writeRegister != 5'd0) begin
      model_regs[writeRegister] = writeData;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (reset || a == 5'd0) return 32'd0;
    return model_regs[a];
  endfunction

  // Opcode table: {WB, MEM, EX}.
  function automatic logic [8:0] model_ctrl(input logic [5:0] op);
    case (op)
      6'd0:  return {2'b10, 3'b000, 4'b1100};
      6'd35: return {2'b11, 3'b010, 4'b0001};
      6'd43: return {2'b00, 3'b001, 4'b0001};
      6'd4:  return {2'b00, 3'b100, 4'b0010};
      6'd8:  return {2'b10, 3'b000, 4'b0001};
      default: return 9'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Compare process: every falling edge, build the expected vector and check it.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [W-1:0] e;
      logic stall;
      stall = idExMemRead && (idExRt == readRegister1 || idExRt == readRegister2);
      exp_q.push_back({model_read(readRegister1), model_read(readRegister2),
                       model_ctrl(opCode), !stall, !stall, stall});
      e = exp_q.pop_front();
      check("rd1",    readData1, e[75:44]);
      check("rd2",    readData2, e[43:12]);
      check("ctrl",   {23'd0, writeBackControl, memAccessControl, calculationControl}, {23'd0, e[11:3]});
      check("hazard", {29'd0, pcWrite, ifIdWrite, bubbleInstruction}, {29'd0, e[2:0]});
    end
  end

  // Driver tasks
  task automatic drive_write(input logic [4:0] a, input logic [31:0] d);
    writeRegister = a;
    writeData     = d;
    regWrite      = 1'b1;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hazard(input logic mr, input logic [4:0] rt, input logic [4:0] rs1, input logic [4:0] rs2);
    idExMemRead   = mr;
    idExRt        = rt;
    readRegister1 = rs1;
    readRegister2 = rs2;
    #1;
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [8:0] ctrl_exp [6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b111111};
    ctrl_exp = '{9'b10_000_1100, 9'b11_010_0001, 9'b00_001_0001,
                 9'b00_100_0010, 9'b10_000_0001, 9'b00_000_0000};

    reset = 1'b1; opCode = '0; readRegister1 = '0; readRegister2 = '0;
    writeRegister = '0; writeData = '0; regWrite = 1'b0;
    idExMemRead = 1'b0; idExRt = '0;
    next_edge();
    check("reset_rd1", readData1, 32'd0);
    reset = 1'b0;
    next_edge();
    chk_en = 1'b1;

    // Reset clears immediately and blocks writes.
    readRegister1 = 5'd5;
    drive_write(5'd5, 32'hDEADBEEF);
    next_edge();
    check("r5_written", readData1, 32'hDEADBEEF);
    regWrite = 1'b0;
    #1 reset = 1'b1;
    #1 check("async_reset_r5", readData1, 32'd0);
    drive_write(5'd5, 32'hCAFEF00D);
    next_edge();
    check("write_under_reset", readData1, 32'd0);
    regWrite = 1'b0;
    reset = 1'b0;
    next_edge();
    check("r5_after_reset", readData1, 32'd0);

    // Write/read and r0.
    drive_write(5'd7, 32'h12345678);
    next_edge();
    drive_write(5'd0, 32'hFFFFFFFF);
    next_edge();
    regWrite = 1'b0;
    writeRegister = 5'd7; writeData = 32'hAAAA5555;
    readRegister1 = 5'd7; readRegister2 = 5'd0;
    #1;
    check("r7_read", readData1, 32'h12345678);
    check("r0_read", readData2, 32'd0);
    next_edge();
    check("r7_no_write", readData1, 32'h12345678);

    // Decoder sweep.
    for (int i = 0; i < 6; i++) begin
      opCode = ops[i];
      #1;
      check("decode", {23'd0, writeBackControl, memAccessControl, calculationControl}, {23'd0, ctrl_exp[i]});
    end

    // Load-use stall and non-stall cases.
    set_hazard(1'b1, 5'd3, 5'd3, 5'd9);
    check("stall_rs", {29'd0, pcWrite, ifIdWrite, bubbleInstruction}, 32'b001);
    set_hazard(1'b1, 5'd3, 5'd9, 5'd3);
    check("stall_rt", {29'd0, pcWrite, ifIdWrite, bubbleInstruction}, 32'b001);
    set_hazard(1'b1, 5'd3, 5'd4, 5'd5);
    check("no_stall_addr", {29'd0, pcWrite, ifIdWrite, bubbleInstruction}, 32'b110);
    set_hazard(1'b0, 5'd3, 5'd3, 5'd3);
    check("no_stall_mr", {29'd0, pcWrite, ifIdWrite, bubbleInstruction}, 32'b110);
    set_hazard(1'b1, 5'd0, 5'd0, 5'd6);
    check("stall_r0", {29'd0, pcWrite, ifIdWrite, bubbleInstruction}, 32'b001);
    idExMemRead = 1'b0;

    // Same-edge write/read.
    drive_write(5'd8, 32'h11);
    next_edge();
    readRegister1 = 5'd8; readRegister2 = 5'd8;
    drive_write(5'd8, 32'h22);
    #1;
    check("r8_before_edge", readData1, 32'h11);
    check("r8_both_ports_pre", readData2, 32'h11);
    next_edge();
    check("r8_after_edge", readData1, 32'h22);
    check("r8_both_ports_post", readData2, 32'h22);
    regWrite = 1'b0;

    // Randomized run, checked by the compare process.
    for (int c = 0; c < 600; c++) begin
      next_edge();
      reset         = ($urandom_range(0, 60) == 0);
      regWrite      = $urandom_range(0, 1);
      writeRegister = $urandom_range(0, 7);
      writeData     = $urandom;
      readRegister1 = $urandom_range(0, 7);
      readRegister2 = $urandom_range(0, 7);
      idExMemRead   = $urandom_range(0, 1);
      idExRt        = $urandom_range(0, 7);
      opCode        = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
    end
    next_edge();
    reset = 1'b0;
    next_edge();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
